pipe_mux_nto1: RTL and testbench
================================

Name: pipe_mux_nto1

Overview:
Parametrised N-to-1 operand select mux for the processor datapath. Generalises the fixed 2:1 selectors to N_IN inputs of WIDTH bits.
- Registered output with a valid/ready handshake.
- 2-entry skid buffer, so IR/RB operand selection can sit in a stallable pipeline stage without combinational ready paths.

Parameters:
WIDTH, 32, data width of each input and of the output
N_IN, 4, number of selectable inputs (>=2)
SEL_W, $clog2(N_IN), select width (localparam, derived; not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_data  input  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
in_sel  input  SEL_W  binary select for this beat
in_valid  input  1  upstream beat present
in_ready  output  1  block can accept a beat this cycle
out_data  output  WIDTH  selected value
out_sel  output  SEL_W  select used for the presented beat (tag)
out_valid  output  1  out_data/out_sel valid
out_ready  input  1  downstream accepts
sel_err  output  1  only with PIPE_MUX_SELCHK_EN; see Optional Feature

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- Reset values: out_valid=0, out_data=0, out_sel=0, in_ready=1, sel_err=0. Skid register and its valid flag are cleared to 0.
- Accept / deliver:
  - A beat is accepted when in_valid && in_ready.
  - A beat is delivered when out_valid && out_ready.
- Selection: accepted value = in_data slice in_sel.
  - in_sel >= N_IN (possible when N_IN is not a power of 2) yields value 0.
  - out_sel still carries the raw in_sel.
- Latency: an accepted beat appears on out_data/out_valid the next cycle (1-cycle latency). No combinational path from in_* to out_*.
- in_ready is a registered output: in_ready = !skid_valid. No combinational path from out_ready to in_ready.
- State machine, with main = output register and skid = overflow register:
  - EMPTY: main invalid. Accept -> ONE, beat loaded into main.
  - ONE, delivery only -> EMPTY.
  - ONE, accept + delivery -> ONE, new beat into main.
  - ONE, accept with no delivery -> FULL, new beat into skid.
  - ONE, neither -> ONE, main held stable.
  - FULL (in_ready=0): delivery -> ONE, skid moves to main, skid cleared. No delivery -> hold.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data and out_sel must not change.
  - Beat order is preserved.
  - No beat is lost or duplicated.
- Throughput: one beat per cycle sustained while out_ready=1.
- in_data and in_sel are ignored (don't care) when in_valid=0 or in_ready=0.
- Reset mid-operation: in-flight beats are discarded, the block returns to EMPTY, and outputs take their reset values immediately (asynchronous).

Optional Feature:
Macro PIPE_MUX_SELCHK_EN.
- Defined:
  - sel_err port exists.
  - Accepting a beat with in_sel >= N_IN sets sel_err on the following clock edge.
  - sel_err is sticky until reset.
  - The beat is still passed through with data 0.
- Not defined:
  - sel_err port absent; no check logic.
  - Out-of-range select still yields data 0.
- When N_IN is a power of 2, sel_err is tied to 0.

Decomposition:
- Shared package pipe_pkg holds:
  - state typedef (EMPTY/ONE/FULL, 2-bit encoding)
  - constant for skid depth (2)
  - function for the select width (clog2)
- Natural sub-module: pipe_skid_reg, a generic WIDTH+SEL_W payload 2-entry skid buffer with the state machine.
- pipe_mux_nto1 = combinational N:1 select feeding pipe_skid_reg, plus the optional check.

Test Plan:
- Reset, then WIDTH=32, N_IN=4; in_data={D3..D0}={0x33,0x22,0x11,0x00}, in_sel=2, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x22, out_sel=2; following cycle out_valid=0.
- Stream of sel 0,1,2,3 back-to-back with out_ready=1 -> outputs 0x00,0x11,0x22,0x33 on consecutive cycles; in_ready stays 1 throughout.
- Backpressure: out_ready=0, send 2 beats (sel 1, then 3) -> in_ready drops to 0 after the second accept; out_data holds 0x11 stable. Raise out_ready -> 0x11 then 0x33 delivered; in_ready returns to 1.
- N_IN=3 with in_sel=3 -> out_data=0, out_sel=3. With PIPE_MUX_SELCHK_EN, sel_err=1 next cycle and stays 1 across later valid beats.
- Assert reset asynchronously while in FULL -> out_valid=0 and in_ready=1 immediately, without waiting for a clk edge. After release, the first beat sent is the first delivered, with no stale data.
- Randomised valid/out_ready (≥10k beats) -> scoreboard sees all beats in order, none dropped or duplicated, out_data stable while stalled.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined operand select mux and its skid buffer.
// Holds the skid state encoding, the skid depth and the select width helper.
package pipe_pkg;

   // Occupancy of the 2-entry skid buffer: main register only, or main plus overflow.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b10
   } skid_state_t;

   localparam int SKID_DEPTH = 2;

   // A select needs at least one bit even for a 2-input mux.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry skid buffer for a P_W-bit payload.
// The main register drives the output; the skid register absorbs the one beat
// that can arrive while downstream stalls, so in_ready is purely registered.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int P_W = 34
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [P_W-1:0] in_payload,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [P_W-1:0] out_payload,
   output logic           out_valid,
   input  logic           out_ready
);

   skid_state_t    state_q;
   skid_state_t    state_d;
   logic [P_W-1:0] main_q;
   logic [P_W-1:0] skid_q;
   logic           main_valid_q;
   logic           skid_valid_q;
   logic           accept;
   logic           deliver;
   logic           load_main;
   logic           load_skid;
   logic           skid_to_main;

   assign accept      = in_valid && in_ready;
   assign deliver     = main_valid_q && out_ready;
   assign in_ready    = !skid_valid_q;
   assign out_valid   = main_valid_q;
   assign out_payload = main_q;

   // Next-state and datapath steering: decide where an accepted beat lands and
   // whether the overflow beat moves forward into the output register.
   always_comb begin
      state_d      = state_q;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d   = ST_ONE;
               load_main = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && deliver) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_d   = ST_FULL;
               load_skid = 1'b1;
            end else if (deliver) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (deliver) begin
               state_d      = ST_ONE;
               skid_to_main = 1'b1;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // State register plus the valid flags derived from the next state, so both
   // out_valid and in_ready come straight from flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_EMPTY;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         main_valid_q <= (state_d != ST_EMPTY);
         skid_valid_q <= (state_d == ST_FULL);
      end
   end

   // Payload registers: main holds steady unless a beat is loaded or the skid
   // beat is promoted; the skid slot is cleared once it has been drained.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main) begin
            main_q <= in_payload;
         end else if (skid_to_main) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_payload;
         end else if (skid_to_main) begin
            skid_q <= '0;
         end
      end
   end

endmodule

// File: rtl/pipe_mux_nto1.sv
// N-to-1 operand select mux with registered valid/ready output.
// A combinational select feeds a 2-entry skid buffer; the selected value and the
// raw select travel together as one payload. Out-of-range selects yield 0.
// Optional macro PIPE_MUX_SELCHK_EN adds a sticky sel_err flag for
// out-of-range selects (tied low when N_IN is a power of two).
module pipe_mux_nto1
   import pipe_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int N_IN  = 4,
   localparam int SEL_W = sel_width(N_IN)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_sel,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef PIPE_MUX_SELCHK_EN
   ,
   output logic                  sel_err
`endif
);

   localparam int P_W = WIDTH + SEL_W;

   logic [WIDTH-1:0] sel_data;
   logic [P_W-1:0]   in_payload;
   logic [P_W-1:0]   out_payload;

   // Select the addressed input; any select beyond the last input falls
   // through to the zero default.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (int'(in_sel) == k) begin
            sel_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign in_payload = {sel_data, in_sel};

   pipe_skid_reg #(
      .P_W (P_W)
   ) u_skid (
      .clk         (clk),
      .reset       (reset),
      .in_payload  (in_payload),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_payload (out_payload),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   assign out_data = out_payload[P_W-1 -: WIDTH];
   assign out_sel  = out_payload[SEL_W-1:0];

`ifdef PIPE_MUX_SELCHK_EN
   generate
      if ((1 << SEL_W) == N_IN) begin : g_selchk_pow2
         assign sel_err = 1'b0;
      end else begin : g_selchk
         logic sel_oor;
         assign sel_oor = (int'(in_sel) >= N_IN);

         // Sticky error: any accepted beat with an out-of-range select latches it.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sel_err <= 1'b0;
            end else if (in_valid && in_ready && sel_oor) begin
               sel_err <= 1'b1;
            end
         end
      end
   endgenerate
`endif

endmodule

// File: tb/tb_pipe_mux_nto1.sv
// Scoreboard testbench for pipe_mux_nto1 (N_IN=4 main instance, N_IN=3 side instance).
module tb_pipe_mux_nto1;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  sel;
   } beat_t;

   localparam logic [127:0] DATA = {32'h33, 32'h22, 32'h11, 32'h00};

   logic         clk;
   logic         reset;
   logic [127:0] in_data;
   logic [1:0]   in_sel;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  out_data;
   logic [1:0]   out_sel;
   logic         out_valid;
   logic         out_ready;

   logic [23:0]  d3_in_data;
   logic [1:0]   d3_in_sel;
   logic         d3_in_valid;
   logic         d3_in_ready;
   logic [7:0]   d3_out_data;
   logic [1:0]   d3_out_sel;
   logic         d3_out_valid;
   logic         d3_out_ready;

`ifdef PIPE_MUX_SELCHK_EN
   logic         sel_err;
   logic         d3_sel_err;
`endif

   beat_t exp_q[$];
   int    check_count;
   int    pass_count;
   logic  rand_ready_en;

   pipe_mux_nto1 #(.WIDTH(32), .N_IN(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef PIPE_MUX_SELCHK_EN
      ,
      .sel_err   (sel_err)
`endif
   );

   pipe_mux_nto1 #(.WIDTH(8), .N_IN(3)) dut3 (
      .clk       (clk),
      .reset     (reset),
      .in_data   (d3_in_data),
      .in_sel    (d3_in_sel),
      .in_valid  (d3_in_valid),
      .in_ready  (d3_in_ready),
      .out_data  (d3_out_data),
      .out_sel   (d3_out_sel),
      .out_valid (d3_out_valid),
      .out_ready (d3_out_ready)
`ifdef PIPE_MUX_SELCHK_EN
      ,
      .sel_err   (d3_sel_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic failNote(input string name);
      check_count++;
      $display("[TB] FAIL %s", name);
   endtask

   // Presents one beat and pushes its expected response once it is seen accepted.
   task automatic applyStimulus(input logic [127:0] data, input logic [1:0] sel,
                                input logic [31:0] exp_data, output int waits);
      beat_t b;
      waits = 0;
      @(posedge clk);
      #1;
      in_data  = data;
      in_sel   = sel;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            b.data = exp_data;
            b.sel  = sel;
            exp_q.push_back(b);
            break;
         end
         waits++;
         if (waits > 1000) begin
            failNote("accept_timeout");
            break;
         end
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(exp_q.size()), 0);
   endtask

   // Monitor: pops and compares on each delivery, and checks hold while stalled.
   initial begin
      beat_t       b;
      logic        stalled;
      logic [31:0] prev_data;
      logic [1:0]  prev_sel;
      stalled = 1'b0;
      prev_data = '0;
      prev_sel = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               checkOutput("stall_valid", 32'(out_valid), 32'd1);
               checkOutput("stall_data", out_data, prev_data);
               checkOutput("stall_sel", 32'(out_sel), 32'(prev_sel));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  failNote("unexpected_beat");
               end else begin
                  b = exp_q.pop_front();
                  checkOutput("beat_data", out_data, b.data);
                  checkOutput("beat_sel", 32'(out_sel), 32'(b.sel));
               end
            end
            stalled   = out_valid && !out_ready;
            prev_data = out_data;
            prev_sel  = out_sel;
         end
      end
   end

   // Random downstream backpressure, active only during the random phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready_en) begin
            out_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   initial begin
      int          waits;
      int          total_waits;
      logic [1:0]  rs;
      logic [127:0] rd;
      check_count   = 0;
      pass_count    = 0;
      rand_ready_en = 1'b0;
      reset         = 1'b1;
      in_data       = '0;
      in_sel        = '0;
      in_valid      = 1'b0;
      out_ready     = 1'b1;
      d3_in_data    = {8'h22, 8'h11, 8'h00};
      d3_in_sel     = '0;
      d3_in_valid   = 1'b0;
      d3_out_ready  = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("rst_out_valid", 32'(out_valid), 0);
      checkOutput("rst_in_ready", 32'(in_ready), 1);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_sel", 32'(out_sel), 0);

      $display("[TB] single beat");
      applyStimulus(DATA, 2'd2, 32'h22, waits);
      idle();
      @(negedge clk);
      checkOutput("single_valid", 32'(out_valid), 1);
      @(negedge clk);
      checkOutput("single_gone", 32'(out_valid), 0);

      $display("[TB] back-to-back stream");
      total_waits = 0;
      for (int s = 0; s < 4; s++) begin
         applyStimulus(DATA, 2'(s), 32'(8'h11 * s), waits);
         total_waits += waits;
      end
      idle();
      checkOutput("stream_ready_waits", 32'(total_waits), 0);
      drain("stream_drain");

      $display("[TB] backpressure");
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      applyStimulus(DATA, 2'd1, 32'h11, waits);
      applyStimulus(DATA, 2'd3, 32'h33, waits);
      idle();
      @(negedge clk);
      checkOutput("bp_in_ready_low", 32'(in_ready), 0);
      checkOutput("bp_hold_data", out_data, 32'h11);
      repeat (2) @(negedge clk);
      checkOutput("bp_hold_data_later", out_data, 32'h11);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain("bp_drain");
      checkOutput("bp_in_ready_back", 32'(in_ready), 1);

      $display("[TB] async reset while full");
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      applyStimulus(DATA, 2'd0, 32'h00, waits);
      applyStimulus(DATA, 2'd2, 32'h22, waits);
      idle();
      @(negedge clk);
      checkOutput("full_before_reset", 32'(in_ready), 0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("areset_out_valid", 32'(out_valid), 0);
      checkOutput("areset_in_ready", 32'(in_ready), 1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      applyStimulus(DATA, 2'd3, 32'h33, waits);
      idle();
      drain("post_reset_drain");

      $display("[TB] out-of-range select, N_IN=3");
`ifdef PIPE_MUX_SELCHK_EN
      checkOutput("selerr_clear", 32'(d3_sel_err), 0);
`endif
      @(posedge clk);
      #1;
      d3_in_sel   = 2'd3;
      d3_in_valid = 1'b1;
      @(posedge clk);
      #1;
      d3_in_valid = 1'b0;
      @(negedge clk);
      checkOutput("oor_valid", 32'(d3_out_valid), 1);
      checkOutput("oor_data", 32'(d3_out_data), 0);
      checkOutput("oor_sel", 32'(d3_out_sel), 3);
`ifdef PIPE_MUX_SELCHK_EN
      checkOutput("selerr_set", 32'(d3_sel_err), 1);
`endif
      @(posedge clk);
      #1;
      d3_in_sel   = 2'd2;
      d3_in_valid = 1'b1;
      @(posedge clk);
      #1;
      d3_in_valid = 1'b0;
      @(negedge clk);
      checkOutput("n3_valid", 32'(d3_out_valid), 1);
      checkOutput("n3_data", 32'(d3_out_data), 32'h22);
      checkOutput("n3_sel", 32'(d3_out_sel), 2);
`ifdef PIPE_MUX_SELCHK_EN
      checkOutput("selerr_sticky", 32'(d3_sel_err), 1);
      checkOutput("selerr_pow2", 32'(sel_err), 0);
`endif

      $display("[TB] random traffic");
      rand_ready_en = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle();
         end
         rd = {$urandom, $urandom, $urandom, $urandom};
         rs = 2'($urandom_range(0, 3));
         applyStimulus(rd, rs, rd[32*rs +: 32], waits);
      end
      idle();
      rand_ready_en = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain("random_drain");

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
